// File: rtl/lab_input_debouncer_pkg.sv
// Shared definitions for the input debouncer: per-channel FSM state encoding
// and the default qualification length.
package lab_input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    W_HIGH = 2'd1,
    S_HIGH = 2'd2,
    W_LOW  = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_WIDTH           = 3;

endpackage

// File: rtl/lab_input_debouncer_if.sv
// Bundle of raw switch levels in and debounced levels/strobes out.
// Level-based, no handshake: raw_in is sampled every clock; db_out, rise, fall
// and changed are registered outputs valid every cycle, rise/fall/changed 1 cycle wide.
interface lab_input_debouncer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (output raw_in, input db_out, rise, fall, changed);
  modport slave  (input raw_in, output db_out, rise, fall, changed);
endinterface

// File: rtl/lab_input_debouncer_channel.sv
// One debounced channel: two-flop synchroniser, stability counter, 4-state FSM
// and registered rise/fall strobes.
module debounce_channel
  import lab_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw,
  output logic      db,
  output logic      rise,
  output logic      fall,
  output db_state_t state_dbg
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          db_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= S_LOW;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      db    <= db_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // Any return to the settled level while waiting restarts qualification.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    db_n    = db;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      S_LOW: begin
        if (s2) begin
          state_n = W_HIGH;
          cnt_n   = CW'(1);
        end
      end
      W_HIGH: begin
        if (!s2) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = S_HIGH;
          cnt_n   = '0;
          db_n    = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_n = W_LOW;
          cnt_n   = CW'(1);
        end
      end
      W_LOW: begin
        if (s2) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = S_LOW;
          cnt_n   = '0;
          db_n    = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: rtl/lab_input_debouncer.sv
// Debounces WIDTH independent switch inputs (bit 2=A, 1=B, 0=C) and
// produces per-channel rise/fall strobes plus a combined changed pulse.
module lab_input_debouncer
  import lab_input_debouncer_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  lab_input_debouncer_if.slave   bus,
  output logic [2*WIDTH-1:0]     dbg_state
);

  logic [WIDTH-1:0] db_v, rise_v, fall_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    db_state_t st;

    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (bus.raw_in[i]),
      .db       (db_v[i]),
      .rise     (rise_v[i]),
      .fall     (fall_v[i]),
      .state_dbg(st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

  // Strobes are already registered, so changed lines up with them in the same cycle.
  assign bus.db_out  = db_v;
  assign bus.rise    = rise_v;
  assign bus.fall    = fall_v;
  assign bus.changed = |(rise_v | fall_v);

endmodule

// File: tb/tb_lab_input_debouncer.sv
// Directed bench for lab_input_debouncer (WIDTH=3, DEBOUNCE_CYCLES=4):
// a per-cycle vector table plus hand-written bounce and reset sequences.
module tb_lab_input_debouncer;

  localparam int W = 3;

  logic clk;
  logic rst;
  logic [2*W-1:0] dbg_state;

  lab_input_debouncer_if #(.WIDTH(W)) bus ();

  lab_input_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } vec_t;

  vec_t vecs[$];
  logic [3*W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs, then compare outputs of that edge
  task automatic apply(input logic r, input logic [W-1:0] raw,
                       input logic [W-1:0] e_db, input logic [W-1:0] e_rise,
                       input logic [W-1:0] e_fall, input logic e_chg);
    logic [3*W:0] e;
    @(negedge clk);
    rst        = r;
    bus.raw_in = raw;
    exp_q.push_back({e_db, e_rise, e_fall, e_chg});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("db_out",  bus.db_out,        e[3*W:2*W+1]);
    check("rise",    bus.rise,          e[2*W:W+1]);
    check("fall",    bus.fall,          e[W:1]);
    check("changed", {2'b00, bus.changed}, {2'b00, e[0]});
  endtask

  task automatic add(input int n, input logic r, input logic [W-1:0] raw,
                     input logic [W-1:0] d, input logic [W-1:0] ri,
                     input logic [W-1:0] fa, input logic c);
    for (int k = 0; k < n; k++) vecs.push_back({r, raw, d, ri, fa, c});
  endtask

  initial begin
    rst        = 1'b1;
    bus.raw_in = '0;

    // reset with inputs held high, then qualification after release
    add(3, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0);
    add(5, 0, 3'b111, 3'b000, 3'b000, 3'b000, 0);
    add(1, 0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
    add(1, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0);
    // all channels fall together
    add(5, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0);
    add(1, 0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
    add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    // 3-cycle glitch on C is rejected
    add(3, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
    add(6, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    // A and C rise together
    add(5, 0, 3'b101, 3'b000, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 3'b101, 3'b101, 3'b000, 1);
    add(1, 0, 3'b101, 3'b101, 3'b000, 3'b000, 0);
    // B joins
    add(5, 0, 3'b111, 3'b101, 3'b000, 3'b000, 0);
    add(1, 0, 3'b111, 3'b111, 3'b010, 3'b000, 1);
    add(1, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0);
    // A falls alone
    add(5, 0, 3'b011, 3'b111, 3'b000, 3'b000, 0);
    add(1, 0, 3'b011, 3'b011, 3'b000, 3'b100, 1);
    add(1, 0, 3'b011, 3'b011, 3'b000, 3'b000, 0);
    // back to all low
    add(5, 0, 3'b000, 3'b011, 3'b000, 3'b000, 0);
    add(1, 0, 3'b000, 3'b000, 3'b000, 3'b011, 1);
    add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].raw, vecs[i].db, vecs[i].rise, vecs[i].fall, vecs[i].chg);

    // B bounces every cycle for 10 cycles, then holds high
    for (int i = 0; i < 10; i++)
      apply(0, (i % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 3'b000, 3'b000, 0);
    for (int h = 1; h <= 5; h++)
      apply(0, 3'b010, 3'b000, 3'b000, 3'b000, 0);
    apply(0, 3'b010, 3'b010, 3'b010, 3'b000, 1);
    apply(0, 3'b010, 3'b010, 3'b000, 3'b000, 0);
    for (int h = 1; h <= 5; h++)
      apply(0, 3'b000, 3'b010, 3'b000, 3'b000, 0);
    apply(0, 3'b000, 3'b000, 3'b000, 3'b010, 1);
    apply(0, 3'b000, 3'b000, 3'b000, 3'b000, 0);

    // reset lands while A is mid-qualification
    for (int e = 1; e <= 3; e++)
      apply(0, 3'b100, 3'b000, 3'b000, 3'b000, 0);
    apply(1, 3'b100, 3'b000, 3'b000, 3'b000, 0);
    n_checks++;
    if (dbg_state !== 6'b000000) begin
      n_fail++;
      $display("FAIL dbg_state after reset: got %b expected %b", dbg_state, 6'b000000);
    end
    for (int e = 1; e <= 5; e++)
      apply(0, 3'b100, 3'b000, 3'b000, 3'b000, 0);
    apply(0, 3'b100, 3'b100, 3'b100, 3'b000, 1);
    apply(0, 3'b100, 3'b100, 3'b000, 3'b000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
